// File: rtl/sram_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sram_pkg
//  Purpose  : Shared SRAM frame-buffer geometry and write-FSM state encoding.
//             Used by both the frame writer and the SRAM pixel decoder so that
//             nibble order within a word is identical on both sides.
//  Contents : SRAM_ADDR_W, SRAM_DATA_W, PIX_W, PIX_PER_WORD, CNT_W, wr_state_t
//  Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

  localparam int SRAM_ADDR_W  = 20;
  localparam int SRAM_DATA_W  = 16;
  localparam int PIX_W        = 4;
  localparam int PIX_PER_WORD = 4;
  localparam int CNT_W        = 2;

  // Write cycle: SETUP presents addr/data, STROBE pulses we, HOLD keeps the
  // bus driven so data hold time is met after we falls.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wr_state_t;

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_frame_writer_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pixel_packer
//  Purpose  : Packs 4-bit palette indices into 16-bit words (pixel k of a
//             word in bits [4k+3:4k]) and holds one completed word in a
//             pending register until the writer pops it.
//  Ports    : i_clk, i_rst_n   - clock, async active-low reset
//             i_clear          - discard partial word and pending word
//             i_pix_valid/i_pix_idx/i_pix_last, o_pix_ready - pixel handshake
//             i_pop            - pending word has been written
//             o_pend_valid/o_pend_data/o_pend_last - pending word
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_packer
  import sram_pkg::*;
#(
  parameter logic [PIX_W-1:0] P_PAD_IDX = 4'h0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_pix_valid,
  input  logic [PIX_W-1:0]       i_pix_idx,
  input  logic                   i_pix_last,
  output logic                   o_pix_ready,
  input  logic                   i_pop,
  output logic                   o_pend_valid,
  output logic [SRAM_DATA_W-1:0] o_pend_data,
  output logic                   o_pend_last
);

  logic [CNT_W-1:0]       r_cnt;
  logic [SRAM_DATA_W-1:0] r_acc;
  logic                   r_pend_valid;
  logic [SRAM_DATA_W-1:0] r_pend_data;
  logic                   r_pend_last;

  logic                   w_accept;
  logic                   w_flush;
  logic [SRAM_DATA_W-1:0] w_word;

  // A clear in the same cycle as a valid pixel drops that pixel.
  assign w_accept = i_pix_valid && !r_pend_valid && !i_clear;
  assign w_flush  = w_accept && ((r_cnt == CNT_W'(PIX_PER_WORD - 1)) || i_pix_last);

  // Word as it would look with the incoming pixel merged in; nibbles beyond
  // the incoming one carry the pad index so a partial final word is complete.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (k < int'(r_cnt))
        w_word[k*PIX_W +: PIX_W] = r_acc[k*PIX_W +: PIX_W];
      else if (k == int'(r_cnt))
        w_word[k*PIX_W +: PIX_W] = i_pix_idx;
      else
        w_word[k*PIX_W +: PIX_W] = P_PAD_IDX;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_pend_last  <= 1'b0;
    end else if (i_clear) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_last  <= 1'b0;
    end else begin
      // Pop and accept are mutually exclusive: accept needs an empty pending
      // register, pop only happens while it is full.
      if (i_pop) begin
        r_pend_valid <= 1'b0;
        r_pend_last  <= 1'b0;
      end
      if (w_accept) begin
        if (w_flush) begin
          r_pend_valid <= 1'b1;
          r_pend_data  <= w_word;
          r_pend_last  <= i_pix_last;
          r_cnt        <= '0;
          r_acc        <= '0;
        end else begin
          r_acc <= w_word;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_pix_ready  = !r_pend_valid;
  assign o_pend_valid = r_pend_valid;
  assign o_pend_data  = r_pend_data;
  assign o_pend_last  = r_pend_last;

endmodule : pixel_packer
`default_nettype wire

// File: rtl/sram_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sram_frame_writer
//  Purpose  : Accepts a stream of palette indices, packs them four per word
//             and writes the words to consecutive SRAM addresses while the
//             write window is open, using a 4-cycle SETUP/STROBE/HOLD cycle.
//  Ports    : i_clk, i_rst_n          - clock, async active-low reset
//             i_start                 - restart frame at P_BASE_ADDR
//             i_pix_valid/idx/last, o_pix_ready - pixel stream handshake
//             i_wr_window             - SRAM write permitted
//             o_sram_we/addr/data/drive - SRAM write interface
//             o_busy, o_frame_done    - status
//  Revision : 1.0 - initial release
// ============================================================================
module sram_frame_writer
  import sram_pkg::*;
#(
  parameter logic [SRAM_ADDR_W-1:0] P_BASE_ADDR   = 20'h00000,
  parameter int                     P_FRAME_WORDS = 76800,
  parameter logic [PIX_W-1:0]       P_PAD_IDX     = 4'h0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_pix_valid,
  input  logic [PIX_W-1:0]       i_pix_idx,
  input  logic                   i_pix_last,
  output logic                   o_pix_ready,
  input  logic                   i_wr_window,
  output logic                   o_sram_we,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr,
  output logic [SRAM_DATA_W-1:0] o_sram_data,
  output logic                   o_sram_drive,
  output logic                   o_busy,
  output logic                   o_frame_done
);

  localparam logic [SRAM_ADDR_W-1:0] C_LAST_ADDR =
    SRAM_ADDR_W'(int'(P_BASE_ADDR) + P_FRAME_WORDS - 1);

  wr_state_t              r_state;
  wr_state_t              w_state_nxt;
  logic [SRAM_ADDR_W-1:0] r_ptr;
  logic [SRAM_DATA_W-1:0] r_data;
  logic                   r_start_pend;
  logic                   r_frame_done;

  logic                   w_launch;
  logic                   w_we;
  logic                   w_drive;
  logic                   w_clear;
  logic                   w_pop;
  logic                   w_pend_valid;
  logic [SRAM_DATA_W-1:0] w_pend_data;
  logic                   w_pend_last;
  logic [SRAM_ADDR_W-1:0] w_ptr_inc;

  // A start seen in IDLE takes effect at once, including the pending word.
  // A start during a write cycle is deferred until HOLD exits, at which point
  // the pending word is popped anyway and the packer count is already zero.
  assign w_clear = (r_state == IDLE) && i_start;
  assign w_pop   = (r_state == HOLD);

  pixel_packer #(
    .P_PAD_IDX (P_PAD_IDX)
  ) u_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_clear),
    .i_pix_valid  (i_pix_valid),
    .i_pix_idx    (i_pix_idx),
    .i_pix_last   (i_pix_last),
    .o_pix_ready  (o_pix_ready),
    .i_pop        (w_pop),
    .o_pend_valid (w_pend_valid),
    .o_pend_data  (w_pend_data),
    .o_pend_last  (w_pend_last)
  );

  assign w_ptr_inc = (r_ptr == C_LAST_ADDR) ? P_BASE_ADDR : r_ptr + SRAM_ADDR_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // The window is only looked at in IDLE; once launched a write always runs
  // to completion so the SRAM never sees a truncated cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_we        = 1'b0;
    w_drive     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_start && w_pend_valid && i_wr_window) begin
          w_launch    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_drive     = 1'b1;
        w_state_nxt = STROBE;
      end
      STROBE: begin
        w_drive     = 1'b1;
        w_we        = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        w_drive     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr        <= P_BASE_ADDR;
      r_data       <= '0;
      r_start_pend <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start)       r_ptr  <= P_BASE_ADDR;
          else if (w_launch) r_data <= w_pend_data;
        end
        SETUP, STROBE: begin
          if (i_start) r_start_pend <= 1'b1;
        end
        HOLD: begin
          r_start_pend <= 1'b0;
          r_frame_done <= w_pend_last;
          // End of frame or a deferred start both rewind instead of advancing.
          if (r_start_pend || i_start || w_pend_last) r_ptr <= P_BASE_ADDR;
          else                                        r_ptr <= w_ptr_inc;
        end
        default: ;
      endcase
    end
  end

  assign o_sram_we    = w_we;
  assign o_sram_drive = w_drive;
  assign o_sram_addr  = r_ptr;
  assign o_sram_data  = r_data;
  assign o_busy       = w_pend_valid || (r_state != IDLE);
  assign o_frame_done = r_frame_done;

endmodule : sram_frame_writer
`default_nettype wire

// File: tb/tb_sram_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sram_frame_writer
//  Purpose  : Directed self-checking bench for sram_frame_writer. A second
//             instance with a 3-word frame and pad index F shares the stimulus
//             so address wrap and padding parameters can be observed cheaply.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_frame_writer;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic        pix_valid = 1'b0;
  logic [3:0]  pix_idx   = 4'h0;
  logic        pix_last  = 1'b0;
  logic        wr_window = 1'b0;

  logic        m_ready, m_we, m_drive, m_busy, m_done;
  logic [19:0] m_addr;
  logic [15:0] m_data;
  logic        x_ready, x_we, x_drive, x_busy, x_done;
  logic [19:0] x_addr;
  logic [15:0] x_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [19:0] m_addr_q[$];
  logic [15:0] m_data_q[$];
  logic [19:0] x_addr_q[$];
  logic [15:0] x_data_q[$];
  int          m_done_cnt = 0;

  always #5 clk = ~clk;

  sram_frame_writer u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_pix_valid  (pix_valid),
    .i_pix_idx    (pix_idx),
    .i_pix_last   (pix_last),
    .o_pix_ready  (m_ready),
    .i_wr_window  (wr_window),
    .o_sram_we    (m_we),
    .o_sram_addr  (m_addr),
    .o_sram_data  (m_data),
    .o_sram_drive (m_drive),
    .o_busy       (m_busy),
    .o_frame_done (m_done)
  );

  sram_frame_writer #(
    .P_BASE_ADDR   (20'h00000),
    .P_FRAME_WORDS (3),
    .P_PAD_IDX     (4'hF)
  ) u_dut_wrap (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_pix_valid  (pix_valid),
    .i_pix_idx    (pix_idx),
    .i_pix_last   (pix_last),
    .o_pix_ready  (x_ready),
    .i_wr_window  (wr_window),
    .o_sram_we    (x_we),
    .o_sram_addr  (x_addr),
    .o_sram_data  (x_data),
    .o_sram_drive (x_drive),
    .o_busy       (x_busy),
    .o_frame_done (x_done)
  );

  // Write/strobe log sampled on the falling edge.
  always @(negedge clk) begin
    if (m_we) begin
      m_addr_q.push_back(m_addr);
      m_data_q.push_back(m_data);
    end
    if (x_we) begin
      x_addr_q.push_back(x_addr);
      x_data_q.push_back(x_data);
    end
    if (m_done) m_done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] idx, input logic last);
    int n;
    pix_valid = 1'b1;
    pix_idx   = idx;
    pix_last  = last;
    n = 0;
    while (!m_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout", {31'd0, m_ready}, 32'd1);
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic send4_fast(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    pix_valid = 1'b1;
    pix_idx = a; tick();
    pix_idx = b; tick();
    pix_idx = c; tick();
    pix_idx = d; tick();
    pix_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (m_addr_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("write_timeout", m_addr_q.size(), n);
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (m_busy && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("idle_timeout", {31'd0, m_busy}, 32'd0);
  endtask

  initial begin
    int base;
    int xbase;
    int done0;

    // ---------------- reset values ----------------
    #2;
    chk("rst_we",    {31'd0, m_we},    32'd0);
    chk("rst_drive", {31'd0, m_drive}, 32'd0);
    chk("rst_addr",  m_addr,           32'h0);
    chk("rst_data",  m_data,           32'h0);
    chk("rst_busy",  {31'd0, m_busy},  32'd0);
    chk("rst_done",  {31'd0, m_done},  32'd0);
    chk("rst_ready", {31'd0, m_ready}, 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // ---------------- T1: window high, 1,2,3,4 back-to-back ----------------
    wr_window = 1'b1;
    send4_fast(4'h1, 4'h2, 4'h3, 4'h4);
    chk("t1_ready_stall", {31'd0, m_ready}, 32'd0);
    chk("t1_busy",        {31'd0, m_busy},  32'd1);
    chk("t1_we_pend",     {31'd0, m_we},    32'd0);
    tick();  // SETUP
    chk("t1_setup_drive", {31'd0, m_drive}, 32'd1);
    chk("t1_setup_we",    {31'd0, m_we},    32'd0);
    chk("t1_setup_addr",  m_addr,           32'h0);
    chk("t1_setup_data",  m_data,           32'h4321);
    tick();  // STROBE: third cycle after the 4th pixel was taken
    chk("t1_strobe_we",   {31'd0, m_we},    32'd1);
    chk("t1_strobe_addr", m_addr,           32'h0);
    chk("t1_strobe_data", m_data,           32'h4321);
    tick();  // HOLD
    chk("t1_hold_we",     {31'd0, m_we},    32'd0);
    chk("t1_hold_drive",  {31'd0, m_drive}, 32'd1);
    tick();  // IDLE
    chk("t1_idle_drive",  {31'd0, m_drive}, 32'd0);
    chk("t1_idle_busy",   {31'd0, m_busy},  32'd0);
    chk("t1_idle_ready",  {31'd0, m_ready}, 32'd1);
    chk("t1_next_addr",   m_addr,           32'h1);
    chk("t1_one_strobe",  m_addr_q.size(),  32'd1);

    // ---------------- T2: window low, 8 pixels ----------------
    wr_window = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_start_addr", m_addr, 32'h0);
    base  = m_addr_q.size();
    xbase = x_addr_q.size();
    send4_fast(4'h1, 4'h2, 4'h3, 4'h4);
    repeat (6) tick();
    chk("t2_ready_low", {31'd0, m_ready}, 32'd0);
    chk("t2_no_we",     m_addr_q.size(),  base);
    chk("t2_busy",      {31'd0, m_busy},  32'd1);
    wr_window = 1'b1;
    send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
    wait_writes(base + 2);
    wait_idle();
    chk("t2_w0_addr", m_addr_q[base],   32'h0);
    chk("t2_w0_data", m_data_q[base],   32'h4321);
    chk("t2_w1_addr", m_addr_q[base+1], 32'h1);
    chk("t2_w1_data", m_data_q[base+1], 32'h8765);
    chk("t2_x_w1_addr", x_addr_q[xbase+1], 32'h1);

    // ---------------- T3: partial last word ----------------
    start = 1'b1; tick(); start = 1'b0;
    base  = m_addr_q.size();
    xbase = x_addr_q.size();
    done0 = m_done_cnt;
    send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b0); send(4'hD, 1'b0);
    send(4'hE, 1'b0); send(4'hF, 1'b1);
    wait_writes(base + 2);
    wait_idle();
    chk("t3_done_pulse", {31'd0, m_done}, 32'd1);
    tick();
    chk("t3_done_clear", {31'd0, m_done}, 32'd0);
    chk("t3_w0_addr", m_addr_q[base],   32'h0);
    chk("t3_w0_data", m_data_q[base],   32'hDCBA);
    chk("t3_w1_addr", m_addr_q[base+1], 32'h1);
    chk("t3_w1_data", m_data_q[base+1], 32'h00FE);
    chk("t3_x_pad",   x_data_q[xbase+1], 32'hFFFE);
    chk("t3_ptr_base", m_addr, 32'h0);
    chk("t3_x_ptr_base", x_addr, 32'h0);
    chk("t3_done_count", m_done_cnt - done0, 32'd1);

    // ---------------- T4: window dropped during STROBE ----------------
    base = m_addr_q.size();
    send4_fast(4'h1, 4'h1, 4'h2, 4'h2);
    tick();  // SETUP
    chk("t4_setup_addr", m_addr, 32'h0);
    chk("t4_setup_data", m_data, 32'h2211);
    tick();  // STROBE
    chk("t4_strobe_we", {31'd0, m_we}, 32'd1);
    wr_window = 1'b0;
    tick();  // HOLD
    chk("t4_hold_we",    {31'd0, m_we},    32'd0);
    chk("t4_hold_drive", {31'd0, m_drive}, 32'd1);
    chk("t4_hold_addr",  m_addr,           32'h0);
    chk("t4_hold_data",  m_data,           32'h2211);
    tick();  // IDLE
    chk("t4_idle_drive", {31'd0, m_drive}, 32'd0);
    chk("t4_next_addr",  m_addr,           32'h1);
    send4_fast(4'h3, 4'h3, 4'h4, 4'h4);
    repeat (6) tick();
    chk("t4_wait_window", m_addr_q.size(), base + 1);
    chk("t4_wait_busy",   {31'd0, m_busy}, 32'd1);
    wr_window = 1'b1;
    wait_writes(base + 2);
    wait_idle();
    chk("t4_w1_addr", m_addr_q[base+1], 32'h1);
    chk("t4_w1_data", m_data_q[base+1], 32'h4433);

    // ---------------- T5: address wrap at end of frame ----------------
    base  = m_addr_q.size();
    xbase = x_addr_q.size();
    send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
    send(4'h9, 1'b0); send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b0);
    wait_writes(base + 2);
    wait_idle();
    chk("t5_m_w0_addr", m_addr_q[base],    32'h2);
    chk("t5_m_w1_addr", m_addr_q[base+1],  32'h3);
    chk("t5_m_w1_data", m_data_q[base+1],  32'hCBA9);
    chk("t5_x_last",    x_addr_q[xbase],   32'h2);
    chk("t5_x_wrap",    x_addr_q[xbase+1], 32'h0);
    chk("t5_x_ptr",     x_addr,            32'h1);
    chk("t5_m_ptr",     m_addr,            32'h4);

    // ---------------- T6: start during STROBE ----------------
    base = m_addr_q.size();
    send4_fast(4'h1, 4'h2, 4'h3, 4'h4);
    tick();  // SETUP
    tick();  // STROBE
    chk("t6_strobe_we",   {31'd0, m_we}, 32'd1);
    chk("t6_strobe_addr", m_addr,        32'h4);
    chk("t6_x_addr",      x_addr,        32'h1);
    start = 1'b1; tick(); start = 1'b0;  // HOLD
    chk("t6_hold_addr",  m_addr,           32'h4);
    chk("t6_hold_drive", {31'd0, m_drive}, 32'd1);
    tick();  // IDLE
    chk("t6_ptr_base",   m_addr,           32'h0);
    chk("t6_x_ptr_base", x_addr,           32'h0);
    chk("t6_idle_busy",  {31'd0, m_busy},  32'd0);
    chk("t6_no_done",    {31'd0, m_done},  32'd0);
    send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
    wait_writes(base + 2);
    wait_idle();
    chk("t6_w1_addr", m_addr_q[base+1], 32'h0);
    chk("t6_w1_data", m_data_q[base+1], 32'h8765);

    // ---------------- T7: reset during SETUP ----------------
    send4_fast(4'h9, 4'h9, 4'h9, 4'h9);
    tick();  // SETUP
    chk("t7_setup_drive", {31'd0, m_drive}, 32'd1);
    chk("t7_setup_addr",  m_addr,           32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_we",    {31'd0, m_we},    32'd0);
    chk("t7_rst_drive", {31'd0, m_drive}, 32'd0);
    chk("t7_rst_addr",  m_addr,           32'h0);
    chk("t7_rst_data",  m_data,           32'h0);
    chk("t7_rst_busy",  {31'd0, m_busy},  32'd0);
    chk("t7_rst_ready", {31'd0, m_ready}, 32'd1);
    chk("t7_rst_done",  {31'd0, m_done},  32'd0);
    chk("t7_x_drive",   {31'd0, x_drive}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t7_after_we",   {31'd0, m_we},   32'd0);
    chk("t7_after_busy", {31'd0, m_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sram_frame_writer
`default_nettype wire

// File: doc/sram_frame_writer.md
Name: sram_frame_writer

Overview:
Write-side counterpart of the SRAM pixel decoder. It accepts a stream of 4-bit palette indices over a valid/ready handshake and packs four indices into each 16-bit SRAM word. It then writes the words to consecutive SRAM addresses, but only while the top level grants a write window (blanking, when the VGA path is not reading). The block's active-high write enable is the same signal the top level inverts to mark render-fetch slots valid.

Parameters:
P_BASE_ADDR, 20'h00000, word address of the first word of the frame buffer
P_FRAME_WORDS, 76800, words per frame (640x480 pixels / 4); write address wraps after this many words
P_PAD_IDX, 4'h0, index used to fill unused nibbles of a partial final word

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  1-cycle pulse; resets write pointer to P_BASE_ADDR and discards any partial word
i_pix_valid  input  1  pixel index valid
i_pix_idx  input  4  palette index
i_pix_last  input  1  final pixel of frame; qualified by i_pix_valid
o_pix_ready  output  1  block accepts a pixel this cycle
i_wr_window  input  1  SRAM write permitted (high during blanking)
o_sram_we  output  1  SRAM write strobe, active high
o_sram_addr  output  20  SRAM word address
o_sram_data  output  16  write data
o_sram_drive  output  1  data-bus output enable for the top-level tri-state
o_busy  output  1  a pending word or write is in progress
o_frame_done  output  1  1-cycle pulse after the last word of a frame is written

Behaviour:
- One clock domain is used. Reset is asynchronous and active-low; all registers clear on reset.
- Reset values: we=0, drive=0, addr=P_BASE_ADDR, data=0, busy=0, frame_done=0, ready=1.
- A pixel is accepted when valid&&ready. Pixel k of a word (k=0..3 in arrival order) occupies bits [4k+3:4k].
- Packer: a 2-bit count and a 16-bit accumulator. On the 4th pixel, or on an accepted pixel with last=1, {acc, last flag} moves to the pending register (pend_valid=1) in the next cycle and count clears. For a partial final word, the unused nibbles are filled with P_PAD_IDX.
- o_pix_ready = !pend_valid. The accumulator never overflows because a transfer needs an empty pending register.
- Write FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if pend_valid && i_wr_window at cycle n, go to SETUP at n+1.
  - SETUP: addr and data are registered and stable; drive=1, we=0.
  - STROBE: we=1 for exactly one cycle.
  - HOLD: we=0, drive=1. On exit, pend_valid clears, the pointer increments, and the state returns to IDLE (n+4).
  - Minimum write period is 4 cycles per word. addr and data do not change from SETUP through HOLD.
- i_wr_window is sampled only in IDLE. If the window drops during SETUP, STROBE or HOLD, the in-flight write still completes.
- Pointer wrap: an increment from P_BASE_ADDR+P_FRAME_WORDS-1 wraps to P_BASE_ADDR.
- Last word: after HOLD, the pointer goes to P_BASE_ADDR and o_frame_done pulses for the cycle after HOLD.
- i_start:
  - In IDLE: pointer goes to base and count clears. An un-launched pending word is also discarded.
  - In SETUP, STROBE or HOLD: the write completes, then the start takes effect. The post-HOLD increment is suppressed and the pointer goes to base.
  - If i_start coincides with an accepted pixel, the start wins and the pixel is dropped.
- o_busy = pend_valid || (state != IDLE).
- Mid-operation reset: everything returns to reset values immediately and we deasserts asynchronously.

Decomposition:
- Shared package sram_pkg: SRAM_ADDR_W=20, SRAM_DATA_W=16, PIX_W=4, PIX_PER_WORD=4, and the typedef enum wr_state_t {IDLE, SETUP, STROBE, HOLD}. The SRAM decoder also uses this package so the nibble order is identical on both sides.
- One sub-module, pixel_packer: the count, accumulator and pending register, with the handshake. The FSM and pointer stay in the top of the block.

Test Plan:
- Window held high; pixels 1,2,3,4 sent back-to-back -> one write at addr 0x00000, data 16'h4321. we is high exactly one cycle, 3 cycles after pend_valid rises.
- Window low; 8 pixels sent -> ready drops after the 4th pixel and no we occurs. Raise the window -> words at 0x00000 and 0x00001, data 16'h4321 then 16'h8765.
- 6 pixels A,B,C,D,E,F with last on F -> second word 16'h00FE at 0x00001, o_frame_done pulses once, and the pointer returns to 0x00000.
- Window dropped on the STROBE cycle -> the write completes (we=1 for one cycle, addr/data stable for 3 cycles). The next word waits for the window.
- Pointer at 76799 (0x12BFF) when a word is written -> the next word goes to 0x00000.
- i_start during STROBE, and separately rst_n pulled low during SETUP:
  - i_start: the write completes and the next word goes to 0x00000.
  - reset: we/drive go low with no clock edge, and all outputs take their reset values.
